// File: rtl/proc_pkg.sv
// Shared opcodes, instruction field positions and sign extension for the two-stage core.
package proc_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_ADDI = 4'h6;
   localparam logic [3:0] OP_LI   = 4'h7;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_BNE  = 4'h9;
   localparam logic [3:0] OP_J    = 4'hA;
   localparam logic [3:0] OP_SLL  = 4'hB;
   localparam logic [3:0] OP_SLT  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int OP_HI = 15;
   localparam int OP_LO = 12;
   localparam int A_HI  = 11;
   localparam int A_LO  = 9;
   localparam int B_HI  = 8;
   localparam int B_LO  = 6;
   localparam int C_HI  = 5;
   localparam int C_LO  = 3;

   // Sign-extends the low 'width' bits of value to 64 bits; callers truncate.
   function automatic logic [63:0] sext(input logic [11:0] value, input int width);
      logic [63:0] ext;
      ext = {52'd0, value} & ~({64{1'b1}} << width);
      if (ext[6'(width - 1)]) begin
         ext = ext | ({64{1'b1}} << width);
      end
      return ext;
   endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: the core feeds it prepared operands, including immediates.
module proc_alu
   import proc_pkg::*;
#(
   parameter int XLEN = 8
) (
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result,
   output logic            eq
);

   localparam int SH_W = $clog2(XLEN);

   always_comb begin
      result = '0;
      case (op)
         OP_ADD, OP_ADDI: result = a + b;
         OP_SUB:          result = a - b;
         OP_AND:          result = a & b;
         OP_OR:           result = a | b;
         OP_XOR:          result = a ^ b;
         OP_SLL:          result = a << b[SH_W-1:0];
         OP_SLT:          result = XLEN'($signed(a) < $signed(b));
         OP_LI:           result = b;
         default:         result = '0;
      endcase
   end

   assign eq = (a == b);

endmodule

// File: rtl/processor2stage_p.sv
// Two-stage fetch/execute core with taken-branch flush, HALT, writeback strobe
// and a saturating retired-instruction counter.
module processor2stage_p
   import proc_pkg::*;
#(
   parameter int XLEN = 8,
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   output logic [PC_W-1:0] instr_addr,
   input  logic [15:0]     instr_data,
   output logic [PC_W-1:0] pc_out,
   output logic [XLEN-1:0] result_out,
   output logic            result_valid,
   output logic            halted,
   output logic [15:0]     retired
);

   logic [PC_W-1:0] pc_reg;
   logic            ifex_valid_reg;
   logic [15:0]     ifex_instr_reg;
   logic [PC_W-1:0] ifex_pc_reg;
   logic [XLEN-1:0] rf_reg [8];
   logic [XLEN-1:0] result_reg;
   logic            result_valid_reg;
   logic            halted_reg;
   logic [15:0]     retired_reg;

   logic [3:0]      op;
   logic [2:0]      ra;
   logic [2:0]      rb;
   logic [2:0]      rc;
   logic [XLEN-1:0] opa;
   logic [XLEN-1:0] opb;
   logic [XLEN-1:0] alu_result;
   logic            alu_eq;
   logic            exec;
   logic            writes_rd;
   logic            write_en;
   logic            branch_taken;
   logic            halt_now;
   logic [PC_W-1:0] target;

   assign op   = ifex_instr_reg[OP_HI:OP_LO];
   assign ra   = ifex_instr_reg[A_HI:A_LO];
   assign rb   = ifex_instr_reg[B_HI:B_LO];
   assign rc   = ifex_instr_reg[C_HI:C_LO];
   assign exec = ifex_valid_reg && !halted_reg;

   // rf_reg[0] is never written, so reading r0 yields zero.
   always_comb begin
      opa = rf_reg[rb];
      opb = rf_reg[rc];
      case (op)
         OP_ADDI: opb = XLEN'(sext({6'd0, ifex_instr_reg[5:0]}, 6));
         OP_LI:   opb = XLEN'(sext({3'd0, ifex_instr_reg[8:0]}, 9));
         OP_BEQ, OP_BNE: begin
            opa = rf_reg[ra];
            opb = rf_reg[rb];
         end
         default: ;
      endcase
   end

   proc_alu #(.XLEN(XLEN)) u_alu (
      .op     (op),
      .a      (opa),
      .b      (opb),
      .result (alu_result),
      .eq     (alu_eq)
   );

   always_comb begin
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
         OP_ADDI, OP_LI, OP_SLL, OP_SLT: writes_rd = 1'b1;
         default:                        writes_rd = 1'b0;
      endcase
   end

   assign write_en     = exec && writes_rd && (ra != 3'd0);
   assign halt_now     = exec && (op == OP_HALT);
   assign branch_taken = exec && (((op == OP_BEQ) && alu_eq) ||
                                  ((op == OP_BNE) && !alu_eq) ||
                                  (op == OP_J));
   assign target = ifex_pc_reg + ((op == OP_J) ?
                   PC_W'(sext(ifex_instr_reg[11:0], 12)) :
                   PC_W'(sext({6'd0, ifex_instr_reg[5:0]}, 6)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg           <= '0;
         ifex_valid_reg   <= 1'b0;
         ifex_instr_reg   <= '0;
         ifex_pc_reg      <= '0;
         result_reg       <= '0;
         result_valid_reg <= 1'b0;
         halted_reg       <= 1'b0;
         retired_reg      <= '0;
         for (int i = 0; i < 8; i++) begin
            rf_reg[i] <= '0;
         end
      end else begin
         result_valid_reg <= 1'b0;
         if (!halted_reg) begin
            // HALT and taken branches both squash the instruction fetched this cycle.
            if (halt_now) begin
               halted_reg     <= 1'b1;
               ifex_valid_reg <= 1'b0;
            end else if (branch_taken) begin
               pc_reg         <= target;
               ifex_valid_reg <= 1'b0;
            end else begin
               ifex_valid_reg <= 1'b1;
               ifex_instr_reg <= instr_data;
               ifex_pc_reg    <= pc_reg;
               pc_reg         <= pc_reg + PC_W'(1);
            end
            if (exec && (retired_reg != 16'hFFFF)) begin
               retired_reg <= retired_reg + 16'd1;
            end
            if (write_en) begin
               rf_reg[ra]       <= alu_result;
               result_reg       <= alu_result;
               result_valid_reg <= 1'b1;
            end
         end
      end
   end

   assign instr_addr   = pc_reg;
   assign pc_out       = pc_reg;
   assign result_out   = result_reg;
   assign result_valid = result_valid_reg;
   assign halted       = halted_reg;
   assign retired      = retired_reg;

endmodule

// File: tb/tb_processor2stage_p.sv
// Self-checking bench: an instruction-level reference model predicts writebacks,
// their cycle, the halt cycle, retired count and frozen PC for two core widths.
module tb_processor2stage_p;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic sel_w;

   logic [15:0] mem_n [256];
   logic [15:0] mem_w [16];

   logic [7:0]  addr_n, pc_n, res_n;
   logic [15:0] data_n, ret_n;
   logic        rv_n, halt_n;

   logic [3:0]  addr_w, pc_w;
   logic [15:0] res_w, data_w, ret_w;
   logic        rv_w, halt_w;

   assign data_n = mem_n[addr_n];
   assign data_w = mem_w[addr_w];

   processor2stage_p #(.XLEN(8), .PC_W(8)) dut (
      .clk(clk), .reset(reset), .instr_addr(addr_n), .instr_data(data_n),
      .pc_out(pc_n), .result_out(res_n), .result_valid(rv_n),
      .halted(halt_n), .retired(ret_n)
   );

   processor2stage_p #(.XLEN(16), .PC_W(4)) dut_w (
      .clk(clk), .reset(reset), .instr_addr(addr_w), .instr_data(data_w),
      .pc_out(pc_w), .result_out(res_w), .result_valid(rv_w),
      .halted(halt_w), .retired(ret_w)
   );

   logic [7:0]  o_pc, o_addr;
   logic [15:0] o_res, o_ret;
   logic        o_rv, o_halt;
   assign o_pc   = sel_w ? {4'd0, pc_w}   : pc_n;
   assign o_addr = sel_w ? {4'd0, addr_w} : addr_n;
   assign o_res  = sel_w ? res_w : {8'd0, res_n};
   assign o_ret  = sel_w ? ret_w : ret_n;
   assign o_rv   = sel_w ? rv_w : rv_n;
   assign o_halt = sel_w ? halt_w : halt_n;

   int tests = 0;
   int fails = 0;

   logic [15:0] mm [256];
   longint exp_val[$];
   int     exp_edge[$];
   int     exp_retired, exp_pc, exp_halt_edge;
   longint obs_val[$];
   int     obs_edge[$];

   task automatic check(input string tag, input longint got, input longint want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic check_obs(input string tag, input int i, input longint want);
      longint got;
      got = (i < obs_val.size()) ? obs_val[i] : -1;
      check(tag, got, want);
   endtask

   function automatic logic [15:0] enc_r(input int op, input int a, input int b, input int c);
      return {4'(op), 3'(a), 3'(b), 3'(c), 3'b000};
   endfunction
   function automatic logic [15:0] enc_i(input int op, input int a, input int b, input int imm);
      return {4'(op), 3'(a), 3'(b), 6'(imm)};
   endfunction
   function automatic logic [15:0] enc_li(input int a, input int imm);
      return {4'h7, 3'(a), 9'(imm)};
   endfunction
   function automatic logic [15:0] enc_j(input int off);
      return {4'hA, 12'(off)};
   endfunction

   function automatic longint s_imm(input longint v, input int bits);
      if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
      return v;
   endfunction

   // Architectural model: one instruction per step; each taken branch costs one extra cycle.
   task automatic model_run(input int xlen, input int pcw);
      longint regs [8];
      longint xm, va, vb, vc, r, off;
      logic [15:0] ins;
      int pm, pc, k, taken, op, a, b, c, nxt;
      bit wr, tk;
      xm = (longint'(1) << xlen) - 1;
      pm = (1 << pcw) - 1;
      pc = 0; k = 0; taken = 0;
      for (int i = 0; i < 8; i++) regs[i] = 0;
      exp_val.delete(); exp_edge.delete();
      exp_halt_edge = -1; exp_retired = -1; exp_pc = -1;
      for (int step = 0; step < 2000; step++) begin
         ins = mm[pc];
         op = int'(ins[15:12]); a = int'(ins[11:9]); b = int'(ins[8:6]); c = int'(ins[5:3]);
         va = regs[a]; vb = regs[b]; vc = regs[c];
         wr = 1'b1; tk = 1'b0; r = 0; off = 0;
         k++;
         case (op)
            1:  r = vb + vc;
            2:  r = vb - vc;
            3:  r = vb & vc;
            4:  r = vb | vc;
            5:  r = vb ^ vc;
            11: r = vb << (vc % xlen);
            12: r = (s_imm(vb, xlen) < s_imm(vc, xlen)) ? 1 : 0;
            6:  r = vb + s_imm(longint'(ins[5:0]), 6);
            7:  r = s_imm(longint'(ins[8:0]), 9);
            default: wr = 1'b0;
         endcase
         if (op == 8 && va == vb)  begin tk = 1'b1; off = s_imm(longint'(ins[5:0]), 6); end
         if (op == 9 && va != vb)  begin tk = 1'b1; off = s_imm(longint'(ins[5:0]), 6); end
         if (op == 10)             begin tk = 1'b1; off = s_imm(longint'(ins[11:0]), 12); end
         if (op == 15) begin
            exp_halt_edge = 1 + k + taken;
            exp_retired   = k;
            exp_pc        = (pc + 1) & pm;
            return;
         end
         if (wr && a != 0) begin
            regs[a] = r & xm;
            exp_val.push_back(regs[a]);
            exp_edge.push_back(1 + k + taken);
         end
         nxt = tk ? (int'(longint'(pc) + off) & pm) : ((pc + 1) & pm);
         if (tk) taken++;
         pc = nxt;
      end
   endtask

   task automatic clear_mm();
      for (int i = 0; i < 256; i++) mm[i] = 16'hF000;
   endtask

   task automatic load();
      for (int i = 0; i < 256; i++) mem_n[i] = mm[i];
      for (int i = 0; i < 16; i++) mem_w[i] = mm[i];
      model_run(sel_w ? 16 : 8, sel_w ? 4 : 8);
   endtask

   task automatic run_prog(input string name, input int budget);
      int edge_n, halt_seen, extra, n;
      edge_n = 0; halt_seen = -1; extra = 0;
      reset = 1'b0;
      @(negedge clk);
      check({name, " rst_pc"},      o_pc,   0);
      check({name, " rst_result"},  o_res,  0);
      check({name, " rst_valid"},   o_rv,   0);
      check({name, " rst_halted"},  o_halt, 0);
      check({name, " rst_retired"}, o_ret,  0);
      reset = 1'b1;
      obs_val.delete(); obs_edge.delete();
      while (edge_n < budget) begin
         @(posedge clk); #1;
         edge_n++;
         if (o_rv) begin
            obs_val.push_back(longint'(o_res));
            obs_edge.push_back(edge_n);
         end
         if (o_halt && halt_seen < 0) halt_seen = edge_n;
         if (halt_seen >= 0) begin
            extra++;
            if (extra > 3) break;
         end
      end
      check({name, " halt_edge"}, halt_seen, exp_halt_edge);
      check({name, " wb_count"}, obs_val.size(), exp_val.size());
      n = (obs_val.size() < exp_val.size()) ? obs_val.size() : exp_val.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s wb%0d_value", name, i), obs_val[i], exp_val[i]);
         check($sformatf("%s wb%0d_edge", name, i), obs_edge[i], exp_edge[i]);
      end
      check({name, " retired"}, o_ret, exp_retired);
      check({name, " pc_frozen"}, o_pc, exp_pc);
      check({name, " instr_addr"}, o_addr, exp_pc);
      $display("[TB] %s: %0d writebacks, retired %0d, pc %0d", name, obs_val.size(), o_ret, o_pc);
   endtask

   int rops [13] = '{1, 2, 3, 4, 5, 11, 12, 6, 7, 8, 9, 10, 0};

   initial begin
      sel_w = 1'b0;
      reset = 1'b0;
      clear_mm();
      load();

      // LI/ADD
      clear_mm();
      mm[0] = enc_li(1, 5); mm[1] = enc_li(2, 3); mm[2] = enc_r(1, 3, 1, 2);
      load();
      run_prog("li_add", 200);
      check_obs("li_add r1", 0, 5);
      check_obs("li_add r2", 1, 3);
      check_obs("li_add r3", 2, 8);
      check("li_add first_edge", (obs_edge.size() > 0) ? obs_edge[0] : -1, 2);
      check("li_add retired4", o_ret, 4);

      // Back-to-back dependency
      clear_mm();
      mm[0] = enc_i(6, 1, 0, 1);
      for (int i = 1; i < 4; i++) mm[i] = enc_i(6, 1, 1, 1);
      load();
      run_prog("dep", 200);
      for (int i = 0; i < 4; i++) check_obs($sformatf("dep r1_%0d", i), i, i + 1);
      check("dep last_edge_no_stall", (obs_edge.size() > 3) ? obs_edge[3] : -1, 5);

      // Taken branch squashes pc 3/4; BNE r0,r0 falls through
      clear_mm();
      mm[0] = enc_li(1, 1); mm[1] = enc_li(2, 2); mm[2] = enc_i(8, 0, 0, 3);
      mm[3] = enc_li(3, 7); mm[4] = enc_li(4, 9); mm[5] = enc_li(5, 4);
      mm[6] = enc_i(9, 0, 0, 3); mm[7] = enc_li(6, 6);
      load();
      run_prog("branch", 200);
      check_obs("branch target_wb", 2, 4);
      check_obs("branch fallthru_wb", 3, 6);
      check("branch bubble_edge", (obs_edge.size() > 2) ? obs_edge[2] : -1, 6);
      check("branch retired7", o_ret, 7);

      // r0 write and SLT
      clear_mm();
      mm[0] = enc_li(1, -1); mm[1] = enc_li(2, 1); mm[2] = enc_r(1, 0, 1, 1);
      mm[3] = enc_r(12, 3, 1, 2); mm[4] = enc_r(12, 4, 2, 1);
      load();
      run_prog("slt", 200);
      check("slt wb_count4", obs_val.size(), 4);
      check_obs("slt neg_lt_pos", 2, 1);
      check_obs("slt pos_lt_neg", 3, 0);

      // Asynchronous reset between edges, then restart from pc 0
      clear_mm();
      mm[0] = enc_i(6, 1, 0, 1);
      for (int i = 1; i < 4; i++) mm[i] = enc_i(6, 1, 1, 1);
      load();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      check("areset pre_result", o_res, 2);
      reset = 1'b0;
      #1;
      check("areset pc", o_pc, 0);
      check("areset result", o_res, 0);
      check("areset valid", o_rv, 0);
      check("areset retired", o_ret, 0);
      check("areset halted", o_halt, 0);
      run_prog("areset_rerun", 200);

      // Randomized programs on the 8-bit core
      for (int p = 0; p < 6; p++) begin
         int op;
         clear_mm();
         for (int i = 0; i < 4; i++) mm[i] = enc_li(i + 1, int'($urandom_range(0, 511)));
         for (int i = 4; i < 24; i++) begin
            op = rops[$urandom_range(0, 12)];
            case (op)
               7:       mm[i] = enc_li(int'($urandom_range(0, 7)), int'($urandom_range(0, 511)));
               6:       mm[i] = enc_i(6, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                      int'($urandom_range(0, 63)));
               8, 9:    mm[i] = enc_i(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                      int'($urandom_range(1, 4)));
               10:      mm[i] = enc_j(int'($urandom_range(1, 4)));
               0:       mm[i] = 16'h0000;
               default: mm[i] = enc_r(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                      int'($urandom_range(0, 7)));
            endcase
         end
         load();
         run_prog($sformatf("rand%0d", p), 300);
      end

      // Width and PC wrap on the 16-bit / 4-bit-PC core
      sel_w = 1'b1;
      clear_mm();
      mm[0] = enc_i(6, 2, 2, 1); mm[1] = enc_li(1, -1); mm[2] = enc_i(6, 1, 1, 1);
      mm[3] = enc_i(6, 3, 0, 2); mm[4] = enc_i(9, 2, 3, 2);
      for (int i = 6; i < 16; i++) mm[i] = 16'h0000;
      load();
      run_prog("wrap", 300);
      check_obs("wrap li_neg1", 1, 16'hFFFF);
      check_obs("wrap addi_to_zero", 2, 0);
      check_obs("wrap second_pass", 4, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/processor2stage_p.md
# processor2stage_p

Parametrised two-stage (fetch / execute) processor core, the next generation of our fixed 8-bit two-stage core. It adds configurable datapath and PC width, taken-branch flush, a HALT state, a writeback strobe and a retired-instruction counter. Instruction memory is external, with a combinational read. The core sits under the system top and drives the same `pc_out`/`result_out` debug pair the bench monitors.

## Interface
- `XLEN`, 8: datapath and register width (≥4).
- `PC_W`, 8: PC width; instruction memory is word-addressed, 2^PC_W words.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; low clears all state immediately.
- `instr_addr` output PC_W: fetch address, always equal to `pc_out`.
- `instr_data` input 16: instruction word at `instr_addr`, valid in the same cycle.
- `pc_out` output PC_W: current fetch PC.
- `result_out` output XLEN: value of the most recent register writeback.
- `result_valid` output 1: one-cycle pulse in the cycle after a writeback.
- `halted` output 1: high once HALT has executed.
- `retired` output 16: count of executed instructions; saturates at 0xFFFF.

## Operation
- **State.**
  - 8 × XLEN register file; r0 reads 0 and ignores writes.
  - IF/EX register holding `{valid, instr, pc}`.
- **Instruction fields.** op[15:12], a[11:9], b[8:6], c[5:3], imm6[5:0], imm9[8:0].
- **R-type (rd=a, rs1=b, rs2=c):**
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
  - B SLL: shift rs1 left by rs2[$clog2(XLEN)-1:0].
  - C SLT: signed compare, result 1 or 0.
- **I-type and branches:**
  - 6 ADDI: rd=a, rs1=b, sext(imm6).
  - 7 LI: rd=a, value sext(imm9) truncated to XLEN.
  - 8 BEQ / 9 BNE: compare a vs b; target = pc_ex + sext(imm6).
  - A J: target = pc_ex + sext(instr[11:0]).
- **Other opcodes.** F HALT. 0 and all remaining opcodes are NOP.
- **Arithmetic and PC.** All arithmetic is modulo 2^XLEN. PC arithmetic is modulo 2^PC_W, so wrap from all-ones to 0 is legal.
- **Fetch stage.** Latch `instr_data` and `pc` into IF/EX with valid=1, then pc ← pc+1.
- **Execute stage (only when valid).**
  - Read operands and compute in EX.
  - Register write occurs on the clock edge that ends EX.
  - A same-edge write and read therefore needs no forwarding: the next instruction reads the updated file.
- **Taken branch or J.** pc ← target and IF/EX valid ← 0, squashing the wrong-path fetch. A not-taken branch has no effect.
- **HALT.** halted ← 1, IF/EX valid ← 0, pc frozen. The core then stays halted, with no writes and `retired` frozen, until reset.
- **Writeback.** result_out ← written value; result_valid pulses. Writes targeting r0 produce neither.
- **`retired`.** +1 per valid EX instruction, including NOPs, branches and HALT; squashed slots are not counted.

## Timing
- **Reset values.** pc=0, IF/EX valid=0, all registers 0, result_out=0, result_valid=0, halted=0, retired=0.
- **First cycle after reset release.** Fetches address 0. Instruction 0 executes in the following cycle; its result is visible on `result_out` one edge later.
- **Throughput.** Fetch-to-writeback latency is 2 edges; throughput is 1 instruction/cycle.
- **Taken branch.** Exactly 1 bubble; the target is fetched in the cycle after the branch executes.
- **Branch to self (offset 0).** Loops indefinitely; each iteration counts as retired.
- **Reset asserted mid-instruction.** All state clears asynchronously and any in-flight writeback is lost.
- **HALT in EX concurrent with a fetch.** The fetched instruction is discarded.

## Structure
- **Package `proc_pkg`.**
  - Opcode localparams (OP_NOP … OP_HALT).
  - Field bit positions.
  - A `sext` function.
- **Sub-module `proc_alu`** (combinational).
  - Inputs: op, a, b.
  - Outputs: result, eq.
  - Parametrised by XLEN.
- **Top.** Holds the PC, IF/EX register, register file, control and counters.

## Test plan
- **LI/ADD.** Program LI r1,5; LI r2,3; ADD r3,r1,r2; HALT.
  - result_out sequence 5, 3, 8.
  - halted=1, retired=4, pc frozen.
- **Back-to-back dependency.** ADDI r1,r0,1 followed by ADDI r1,r1,1 ×3.
  - result_out 1, 2, 3, 4, with no stall.
- **Taken branch.**
  - BEQ r0,r0,+3 at pc 2: the instruction at pc 3 is squashed and never writes; the next fetch is pc 5; retired excludes the squashed slot.
  - BNE r0,r0 falls through.
- **Width and wrap (XLEN=16, PC_W=4).**
  - LI r1,-1 gives 0xFFFF; ADDI r1,r1,1 gives 0x0000.
  - A NOP stream wraps pc 15→0.
- **Asynchronous reset.** Assert reset mid-program, between clock edges.
  - All outputs are 0 immediately.
  - After release, execution restarts at pc 0.
- **r0 write and SLT.**
  - ADD r0,r1,r1 produces no result_valid.
  - SLT r3 of (-1, 1) gives 1; SLT of (1, -1) gives 0.
